// File: rtl/mismatch_monitor.sv
// mismatch_monitor: compares ref/dut vectors per qualified sample, counts samples and errors, ends on stop or timeout
module mismatch_monitor #(
  parameter int WIDTH   = 1,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] ref_val,
  input  logic [WIDTH-1:0] dut_val,
  input  logic [WIDTH-1:0] care_mask,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic             mismatch_pulse,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  // one extra bit so the counter can step past TIMEOUT-1 on the exit edge
  localparam int CYC_W = $clog2(TIMEOUT) + 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [1:0] state;
  logic [CYC_W-1:0] cyc;
  logic take;
  logic miss;
  // sample qualification and masked compare
  always_comb begin
    take = state == RUN && sample_en;
    miss = take && |((ref_val ^ dut_val) & care_mask);
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  // run control, saturating counters and first-error capture
  always_ff @(posedge clk)
    if (reset) begin
      state           <= IDLE;
      cyc             <= '0;
      timed_out       <= 1'b0;
      mismatch_pulse  <= 1'b0;
      samples         <= '0;
      errors          <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (state != RUN) begin
      mismatch_pulse <= 1'b0;
      if (start) begin
        state           <= RUN;
        cyc             <= '0;
        timed_out       <= 1'b0;
        samples         <= '0;
        errors          <= '0;
        first_err_valid <= 1'b0;
        first_err_idx   <= '0;
      end
    end else begin
      mismatch_pulse <= miss;
      cyc            <= cyc + 1'b1;
      if (stop)
        state <= DONE;
      else if (cyc == CYC_LAST) begin
        state     <= DONE;
        timed_out <= 1'b1;
      end
      if (take && samples != CNT_MAX)
        samples <= samples + 1'b1;
      if (miss && errors != CNT_MAX)
        errors <= errors + 1'b1;
      if (miss && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_idx   <= samples;
      end
    end
endmodule
